// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Holds the FSM states, the datapath select codes and the per-state control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_VEXEC, S_VWB
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_ORR  = 3'b011;
  localparam logic [2:0] ALU_FADD = 3'b100;
  localparam logic [2:0] ALU_VADD = 3'b101;

  localparam logic [3:0] CMD_ADD  = 4'b0100;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0000;
  localparam logic [3:0] CMD_ORR  = 4'b1100;
  localparam logic [3:0] CMD_FADD = 4'b0101;
  localparam logic [3:0] CMD_VADD = 4'b1001;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Moore control word: everything the datapath needs that depends only on state.
  typedef struct packed {
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       vec_w;
    logic       branch;
    logic       alu_op;
    logic       vec_op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_MEMADR: c.alu_src_b = SRCB_IMM;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECR: c.alu_op = 1'b1;
      S_EXECI: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALURESULT;
        c.branch     = 1'b1;
      end
      S_VEXEC: c.vec_op = 1'b1;
      S_VWB:   c.vec_w = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_alu_decode.sv
// ALU function and flag-write decode for execute states.
// Purely combinational; vector ops override the scalar cmd decode.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [4:0] funct,
  input  logic       alu_op,
  input  logic       vec_op,
  output logic [2:0] alu_control,
  output logic [1:0] flag_w
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (vec_op) begin
      alu_control = ALU_VADD;
    end else if (alu_op) begin
      case (cmd)
        CMD_ADD:  alu_control = ALU_ADD;
        CMD_SUB:  alu_control = ALU_SUB;
        CMD_AND:  alu_control = ALU_AND;
        CMD_ORR:  alu_control = ALU_ORR;
        CMD_FADD: alu_control = ALU_FADD;
        default:  alu_control = ALU_ADD;
      endcase
      // Carry/overflow only make sense for the adder-subtractor path.
      flag_w = {s_bit, s_bit & ((alu_control == ALU_ADD) | (alu_control == ALU_SUB))};
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: Moore FSM with registered control word,
// plus a lane counter that iterates VADD over LANES vector lanes.
module mc_controller
  import mc_pkg::*;
#(
  parameter  int LANES  = 4,
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  output logic              IRWrite,
  output logic              NextPC,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic              RegW,
  output logic              MemW,
  output logic              PCS,
  output logic [2:0]        ALUControl,
  output logic [1:0]        FlagW,
  output logic              VecW,
  output logic [LIDX_W-1:0] LaneIdx,
  output logic              Illegal
);

  localparam logic [LIDX_W-1:0] LANE_LAST = LIDX_W'(LANES - 1);

  state_t            state, next_state;
  ctrl_t             ctrl_q, cur;
  logic [LIDX_W-1:0] lane;
  logic              run;
  logic [1:0]        flag_w_raw;

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   next_state = S_MEMADR;
          2'b10:   next_state = S_BRANCH;
          2'b00: begin
            if (Funct[4:1] == CMD_VADD) next_state = S_VEXEC;
            else if (Funct[5])          next_state = S_EXECI;
            else                        next_state = S_EXECR;
          end
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXECR,
      S_EXECI:  next_state = S_ALUWB;
      S_VEXEC:  next_state = S_VWB;
      S_VWB:    next_state = (lane == LANE_LAST) ? S_FETCH : S_VEXEC;
      default:  next_state = S_FETCH;
    endcase
  end

  // The control word is registered from next_state so outputs come straight off flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH);
      lane   <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state);
      if (state == S_VWB)
        lane <= (lane == LANE_LAST) ? '0 : lane + LIDX_W'(1);
      else if (state != S_VEXEC)
        lane <= '0;
    end
  end

  // While reset is high the outputs look like FETCH with every enable suppressed.
  assign run = ~reset;
  assign cur = reset ? state_ctrl(S_FETCH) : ctrl_q;

  mc_alu_decode u_alu_decode (
    .funct       (Funct[4:0]),
    .alu_op      (cur.alu_op),
    .vec_op      (cur.vec_op),
    .alu_control (ALUControl),
    .flag_w      (flag_w_raw)
  );

  assign IRWrite   = cur.ir_write & run;
  assign NextPC    = cur.next_pc & run;
  assign AdrSrc    = cur.adr_src;
  assign ALUSrcA   = cur.alu_src_a;
  assign ALUSrcB   = cur.alu_src_b;
  assign ResultSrc = cur.result_src;
  assign ImmSrc    = Op;
  assign RegSrc    = {Op == 2'b10, Op == 2'b01};
  assign RegW      = cur.reg_w & run;
  assign MemW      = cur.mem_w & run;
  assign VecW      = cur.vec_w & run;
  assign FlagW     = flag_w_raw & {2{run}};
  assign PCS       = cur.branch | (RegW & (Rd == 4'hF));
  assign LaneIdx   = lane;
  assign Illegal   = run & (state == S_DECODE) & (Op == 2'b11);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction cycle schedules built
// from the instruction class, compared every cycle on two DUTs (LANES=4 and LANES=1).
module tb_mc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       adr, asa;
    logic [1:0] asb, rs, imm, regsrc;
    logic       irw, npc, regw, memw, pcs, vecw, illegal;
    logic [2:0] alu;
    logic [1:0] fw, lane;
  } obs_t;

  typedef struct packed {
    logic       adr, asa;
    logic [1:0] asb, rs;
    logic       irw, npc, regw, memw, vecw, branch, illegal;
    logic [2:0] alu;
    logic [1:0] fw, lane;
  } exp_t;

  logic       reset4 = 1'b1, reset1 = 1'b1;
  logic [1:0] op4 = '0, op1 = '0;
  logic [5:0] fn4 = '0, fn1 = '0;
  logic [3:0] rd4 = '0, rd1 = '0;

  logic       irw4, npc4, adr4, asa4, regw4, memw4, pcs4, vecw4, ill4;
  logic [1:0] asb4, rs4, imm4, rsrc4, fw4, lane4;
  logic [2:0] alu4;
  logic       irw1, npc1, adr1, asa1, regw1, memw1, pcs1, vecw1, ill1;
  logic [1:0] asb1, rs1, imm1, rsrc1, fw1;
  logic [2:0] alu1;
  logic [0:0] lane1;

  mc_controller #(.LANES(4)) dut (
    .clk(clk), .reset(reset4), .Op(op4), .Funct(fn4), .Rd(rd4),
    .IRWrite(irw4), .NextPC(npc4), .AdrSrc(adr4), .ALUSrcA(asa4), .ALUSrcB(asb4),
    .ResultSrc(rs4), .ImmSrc(imm4), .RegSrc(rsrc4), .RegW(regw4), .MemW(memw4),
    .PCS(pcs4), .ALUControl(alu4), .FlagW(fw4), .VecW(vecw4), .LaneIdx(lane4),
    .Illegal(ill4)
  );

  mc_controller #(.LANES(1)) dut1 (
    .clk(clk), .reset(reset1), .Op(op1), .Funct(fn1), .Rd(rd1),
    .IRWrite(irw1), .NextPC(npc1), .AdrSrc(adr1), .ALUSrcA(asa1), .ALUSrcB(asb1),
    .ResultSrc(rs1), .ImmSrc(imm1), .RegSrc(rsrc1), .RegW(regw1), .MemW(memw1),
    .PCS(pcs1), .ALUControl(alu1), .FlagW(fw1), .VecW(vecw1), .LaneIdx(lane1),
    .Illegal(ill1)
  );

  obs_t obs4, obs1;
  assign obs4 = {adr4, asa4, asb4, rs4, imm4, rsrc4, irw4, npc4, regw4, memw4,
                 pcs4, vecw4, ill4, alu4, fw4, lane4};
  assign obs1 = {adr1, asa1, asb1, rs1, imm1, rsrc1, irw1, npc1, regw1, memw1,
                 pcs1, vecw1, ill1, alu1, fw1, 1'b0, lane1};

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_instr  = 0;
  exp_t sched[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // ALU meaning of each cmd, straight from the instruction-set table.
  function automatic logic [4:0] alu_model(input logic [3:0] cmd, input logic s);
    logic [2:0] ctl;
    case (cmd)
      4'b0100: ctl = 3'd0;
      4'b0010: ctl = 3'd1;
      4'b0000: ctl = 3'd2;
      4'b1100: ctl = 3'd3;
      4'b0101: ctl = 3'd4;
      default: ctl = 3'd0;
    endcase
    return {ctl, s, s & (ctl <= 3'd1)};
  endfunction

  function automatic exp_t fetch_rec();
    exp_t e = '0;
    e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10; e.irw = 1'b1; e.npc = 1'b1;
    return e;
  endfunction

  function automatic exp_t reset_rec(input logic [1:0] lane);
    exp_t e = fetch_rec();
    e.irw = 1'b0; e.npc = 1'b0; e.lane = lane;
    return e;
  endfunction

  task automatic build(input logic [1:0] op, input logic [5:0] fn, input int lanes);
    exp_t       e;
    logic [4:0] a;
    sched.delete();
    sched.push_back(fetch_rec());
    e = '0; e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10; e.illegal = (op == 2'b11);
    sched.push_back(e);
    case (op)
      2'b01: begin
        e = '0; e.asb = 2'b01; sched.push_back(e);
        if (fn[0]) begin
          e = '0; e.adr = 1'b1; sched.push_back(e);
          e = '0; e.rs = 2'b01; e.regw = 1'b1; sched.push_back(e);
        end else begin
          e = '0; e.adr = 1'b1; e.memw = 1'b1; sched.push_back(e);
        end
      end
      2'b10: begin
        e = '0; e.asb = 2'b01; e.rs = 2'b10; e.branch = 1'b1; sched.push_back(e);
      end
      2'b00: begin
        if (fn[4:1] == 4'b1001) begin
          for (int l = 0; l < lanes; l++) begin
            e = '0; e.alu = 3'b101; e.lane = l[1:0]; sched.push_back(e);
            e = '0; e.vecw = 1'b1; e.lane = l[1:0]; sched.push_back(e);
          end
        end else begin
          a = alu_model(fn[4:1], fn[0]);
          e = '0; e.asb = {1'b0, fn[5]}; e.alu = a[4:2]; e.fw = a[1:0]; sched.push_back(e);
          e = '0; e.regw = 1'b1; sched.push_back(e);
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive(input int w, input logic r, input logic [1:0] op,
                       input logic [5:0] fn, input logic [3:0] rd);
    if (w == 0) begin reset4 = r; op4 = op; fn4 = fn; rd4 = rd; end
    else        begin reset1 = r; op1 = op; fn1 = fn; rd1 = rd; end
  endtask

  task automatic compare(input int w, input exp_t e, input logic [1:0] op,
                         input logic [3:0] rd, input string nm);
    obs_t o;
    logic pcs;
    o   = (w == 0) ? obs4 : obs1;
    pcs = e.branch | (e.regw & (rd == 4'hF));
    check({nm, ".sel"}, 32'({o.adr, o.asa, o.asb, o.rs}), 32'({e.adr, e.asa, e.asb, e.rs}));
    check({nm, ".src"}, 32'({o.imm, o.regsrc}), 32'({op, op == 2'b10, op == 2'b01}));
    check({nm, ".en"}, 32'({o.irw, o.npc, o.regw, o.memw, o.pcs, o.vecw, o.illegal}),
          32'({e.irw, e.npc, e.regw, e.memw, pcs, e.vecw, e.illegal}));
    check({nm, ".alu"}, 32'({o.alu, o.fw}), 32'({e.alu, e.fw}));
    check({nm, ".lane"}, 32'(o.lane), 32'(e.lane));
  endtask

  task automatic do_reset(input int w, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      drive(w, 1'b1, 2'b00, 6'd0, 4'd0);
      #1 compare(w, reset_rec(2'd0), 2'b00, 4'd0, $sformatf("rst_w%0d_%0d", w, i));
    end
  endtask

  // Runs one instruction cycle by cycle; abort_at >= 0 raises reset in that cycle.
  task automatic run_instr(input int w, input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input int abort_at);
    bit aborted = 1'b0;
    build(op, fn, (w == 0) ? 4 : 1);
    n_instr++;
    for (int i = 0; i < sched.size() && !aborted; i++) begin
      @(negedge clk);
      if (i == 0) drive(w, 1'b0, op, fn, rd);
      if (i == abort_at) begin
        drive(w, 1'b1, op, fn, rd);
        #1 compare(w, reset_rec(sched[i].lane), op, rd, $sformatf("i%0d.abort%0d", n_instr, i + 1));
        aborted = 1'b1;
      end else begin
        #1 compare(w, sched[i], op, rd, $sformatf("i%0d.c%0d", n_instr, i + 1));
      end
    end
  endtask

  task automatic run_random(input int w, input int count);
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] rd;
    int         abort_at;
    for (int k = 0; k < count; k++) begin
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      if ($urandom_range(0, 3) == 0) fn[4:1] = 4'b1001;
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 11)) : -1;
      run_instr(w, op, fn, rd, abort_at);
    end
  endtask

  initial begin
    do_reset(0, 2);
    run_instr(0, 2'b01, 6'b011001, 4'd2, -1);  // LDR
    run_instr(0, 2'b00, 6'b001001, 4'd3, -1);  // ADDS register
    run_instr(0, 2'b00, 6'b001001, 4'hF, -1);  // ADDS to PC
    run_instr(0, 2'b00, 6'b100001, 4'd4, -1);  // ANDS immediate
    run_instr(0, 2'b00, 6'b001011, 4'd5, -1);  // FADD with S
    run_instr(0, 2'b00, 6'b110010, 4'd6, -1);  // VADD, four lanes
    run_instr(0, 2'b10, 6'b000000, 4'd0, -1);  // B
    run_instr(0, 2'b11, 6'b000000, 4'd0, -1);  // illegal
    run_instr(0, 2'b00, 6'b110010, 4'd6, 7);   // VADD cut by reset in VWB lane 2
    run_instr(0, 2'b01, 6'b011000, 4'd1, -1);  // STR
    run_random(0, 80);
    do_reset(0, 1);

    do_reset(1, 1);
    run_instr(1, 2'b00, 6'b110010, 4'd7, -1);  // VADD, single lane
    run_instr(1, 2'b00, 6'b000101, 4'hF, -1);  // SUBS to PC
    run_random(1, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit for the ARM datapath; successor to the single-cycle combinational decoder.
- Sequences each instruction through a Moore FSM of FETCH/DECODE/execute/writeback states and drives the multicycle datapath selects and enables.
- Adds a parametrised vector mode: VADD iterates over LANES lanes, one lane per execute/writeback pair, with a lane counter.
- Sits between the instruction register and the condition-check logic, which gates RegW, MemW and PCS with the condition result.

Parameters:
- LANES, 4, number of vector lanes processed by VADD; must be ≥1.
- LIDX_W, max(1,$clog2(LANES)), width of LaneIdx; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20] (I, cmd[3:0], S)
- Rd  in  4  destination register
- IRWrite  out  1  load instruction register
- NextPC  out  1  unconditional PC write (fetch increment)
- AdrSrc  out  1  memory address: 0=PC, 1=ALU result register
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc  out  2  = Op
- RegSrc  out  2  {Op==10, Op==01}
- RegW  out  1  register-file write request
- MemW  out  1  memory write request
- PCS  out  1  PC-source write: Branch state, or RegW with Rd==1111
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 FADD, 101 VADD
- FlagW  out  2  {NZ write, CV write}
- VecW  out  1  vector-lane register write
- LaneIdx  out  LIDX_W  current vector lane
- Illegal  out  1  one-cycle pulse in DECODE when Op==11

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, VEXEC, VWB. Register state updates on posedge clk.
- Reset:
  - State becomes FETCH and LaneIdx becomes 0 on the next edge, including when reset arrives mid-instruction or mid-vector.
  - While reset is high, IRWrite, NextPC, RegW, MemW, VecW, Illegal and FlagW are forced to 0.
  - All other outputs take their FETCH values.
- Default output values: all enables 0, FlagW=00, ALUControl=000 (ADD).
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by Op:
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=00 with cmd=1001 → VEXEC (I bit ignored).
  - Op=00 otherwise: I=1 → EXECI, I=0 → EXECR.
  - Op=11 → FETCH, with Illegal=1.
- MEMADR: ALUSrcA=0, ALUSrcB=01. Next state: S=1 → MEMRD (LDR), S=0 → MEMWR (STR).
- MEMRD: AdrSrc=1. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state: FETCH.
- MEMWR: AdrSrc=1, MemW=1. Next state: FETCH.
- EXECR / EXECI: ALUSrcA=0; ALUSrcB=00 in EXECR, 01 in EXECI. ALU decode active. Next state: ALUWB.
  - cmd 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 0101→FADD, any other cmd→ADD.
  - FlagW[1]=S; FlagW[0]=S & (ADD|SUB).
- ALUWB: ResultSrc=00, RegW=1. Next state: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch asserted. Next state: FETCH.
- VEXEC: ALUSrcA=0, ALUSrcB=00, ALUControl=101, FlagW=00. Next state: VWB.
- VWB: ResultSrc=00, VecW=1, RegW=0.
  - LaneIdx==LANES-1 → LaneIdx←0, next state FETCH.
  - Otherwise LaneIdx←LaneIdx+1, next state VEXEC.
- LaneIdx: never exceeds LANES-1; held at 0 outside vector states. LANES=1 gives a single VEXEC/VWB pass.
- PCS = Branch-state | (RegW & Rd==1111). It is not asserted in VWB because VecW does not count as RegW.
- Latency in cycles: LDR 5, STR 4, data-processing 4, B 3, VADD 2+2·LANES, illegal 2.

Decomposition:
- Package mc_pkg holds:
  - state enum/localparams;
  - ALUControl codes (ALU_ADD … ALU_VADD);
  - cmd field constants (CMD_ADD=0100, CMD_SUB=0010, CMD_AND=0000, CMD_ORR=1100, CMD_FADD=0101, CMD_VADD=1001);
  - ALUSrcB and ResultSrc select codes.
- One combinational sub-module, mc_alu_decode: (Funct, ALUOp, VecOp) → ALUControl, FlagW.
- FSM and lane counter stay in mc_controller.

Test Plan:
- Reset held 2 cycles, then released, with LDR Op=01 Funct=011001 → IRWrite=1 in cycle 1; MEMRD in cycle 4 has AdrSrc=1; RegW=1 only in cycle 5; back to FETCH in cycle 6.
- ADDS register form (Op=00, Funct=001001, Rd=0011) → EXECR shows ALUControl=000, FlagW=11; ALUWB shows RegW=1, PCS=0. Repeat with Rd=1111 → PCS=1 in ALUWB.
- ANDS immediate (Funct=100001) → EXECI shows ALUSrcB=01, ALUControl=010, FlagW=10. FADD (cmd 0101, S=1) → ALUControl=100, FlagW=10.
- VADD (Funct=110010) with LANES=4 → LaneIdx 0,1,2,3 across four VEXEC/VWB pairs, VecW=1 four times, RegW=0 and FlagW=00 throughout; FETCH at cycle 11. Repeat with LANES=1 → FETCH at cycle 5.
- Branch Op=10 → BRANCH in cycle 3 with PCS=1, ALUSrcB=01. Op=11 → Illegal=1 in cycle 2, FETCH in cycle 3, no RegW/MemW at any point.
- Reset asserted during VWB with LaneIdx=2 → next cycle state=FETCH, LaneIdx=0, VecW=0 while reset high; a following STR completes in 4 cycles with MemW=1 only in cycle 4.
